// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring integer divider for the EXE stage.
// One quotient bit per cycle, MSB first; result registered 32 edges after start,
// div_end pulses for one cycle in the following DONE state.
//
// Ports:
//   clk            pipeline clock, rising edge
//   rst            asynchronous active-high reset
//   div_begin      level request; dropping it while busy aborts the division
//   div_sign       1 = signed (DIV), 0 = unsigned (DIVU); sampled at start
//   div_op1        dividend, sampled at start
//   div_op2        divisor, sampled at start
//   div_result     quotient, registered, held until the next completed divide
//   div_remainder  remainder, registered, held until the next completed divide
//   div_end        one-cycle completion strobe
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_begin,
    input  logic             div_sign,
    input  logic [WIDTH-1:0] div_op1,
    input  logic [WIDTH-1:0] div_op2,
    output logic [WIDTH-1:0] div_result,
    output logic [WIDTH-1:0] div_remainder,
    output logic             div_end
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nxt;

    logic [5:0]       cnt;
    logic [WIDTH-1:0] rem;      // partial remainder
    logic [WIDTH-1:0] dvd;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic [WIDTH-1:0] op1_raw;  // original dividend, for the divide-by-zero remainder
    logic             q_neg;
    logic             r_neg;
    logic             dvz;

    logic             last_iter;
    logic [WIDTH+1:0] trial;
    logic             trial_neg;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] dvd_nxt;
    logic [WIDTH-1:0] op1_abs;
    logic [WIDTH-1:0] op2_abs;

    assign last_iter = (cnt == 6'd31);

    assign op1_abs = (div_sign && div_op1[WIDTH-1]) ? -div_op1 : div_op1;
    assign op2_abs = (div_sign && div_op2[WIDTH-1]) ? -div_op2 : div_op2;

    // Trial subtract on the upper WIDTH+1 bits of the shifted {rem, dvd}.
    // A non-negative difference never reaches bit WIDTH (rem < dvs), so any set
    // bit in the top two positions means the trial went negative.
    assign trial     = {1'b0, rem, dvd[WIDTH-1]} - {2'b00, dvs};
    assign trial_neg = |trial[WIDTH+1:WIDTH];

    always_comb begin
        rem_nxt = {rem[WIDTH-2:0], dvd[WIDTH-1]};
        dvd_nxt = {dvd[WIDTH-2:0], 1'b0};
        if (!trial_neg) begin
            rem_nxt = trial[WIDTH-1:0];
            dvd_nxt = {dvd[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (div_begin) state_nxt = BUSY;
            BUSY: begin
                if (!div_begin) begin
                    state_nxt = IDLE;
                end else if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            rem           <= '0;
            dvd           <= '0;
            dvs           <= '0;
            op1_raw       <= '0;
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            dvz           <= 1'b0;
            div_result    <= '0;
            div_remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_begin) begin
                        rem     <= '0;
                        dvd     <= op1_abs;
                        dvs     <= op2_abs;
                        op1_raw <= div_op1;
                        q_neg   <= div_sign & (div_op1[WIDTH-1] ^ div_op2[WIDTH-1]);
                        r_neg   <= div_sign & div_op1[WIDTH-1];
                        dvz     <= (div_op2 == '0);
                        cnt     <= '0;
                    end
                end
                BUSY: begin
                    if (div_begin) begin
                        rem <= rem_nxt;
                        dvd <= dvd_nxt;
                        cnt <= cnt + 6'd1;
                        if (last_iter) begin
                            if (dvz) begin
                                div_result    <= '1;
                                div_remainder <= op1_raw;
                            end else begin
                                div_result    <= q_neg ? -dvd_nxt : dvd_nxt;
                                div_remainder <= r_neg ? -rem_nxt : rem_nxt;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_end = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: timing of div_end, signed and
// unsigned results, divide by zero, abort, back-to-back issue and async reset.
module tb_seq_divider;

    logic        clk;
    logic        rst;
    logic        div_begin;
    logic        div_sign;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic [31:0] div_result;
    logic [31:0] div_remainder;
    logic        div_end;

    int checks;
    int failures;

    seq_divider #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .div_begin     (div_begin),
        .div_sign      (div_sign),
        .div_op1       (div_op1),
        .div_op2       (div_op2),
        .div_result    (div_result),
        .div_remainder (div_remainder),
        .div_end       (div_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Full division starting at the next posedge (E0); div_end expected only in
    // cycle 33. Operands are scrambled mid-division to confirm they are ignored.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq, input logic [31:0] er);
        int end_at;
        int ends;
        logic [31:0] q;
        logic [31:0] r;
        end_at = 0;
        ends   = 0;
        q      = '0;
        r      = '0;
        @(negedge clk);
        div_op1   = a;
        div_op2   = b;
        div_sign  = s;
        div_begin = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (div_end) begin
                ends++;
                if (end_at == 0) begin
                    end_at = k;
                    q = div_result;
                    r = div_remainder;
                end
            end
            if (k == 5) begin
                div_op1  = $urandom;
                div_op2  = $urandom;
                div_sign = ~s;
            end
            if (k == 33) div_begin = 1'b0;
        end
        check({tag, "_end_cycle"}, end_at, 33);
        check({tag, "_end_count"}, ends, 1);
        check({tag, "_q"}, q, eq);
        check({tag, "_r"}, r, er);
        check({tag, "_q_hold"}, div_result, eq);
    endtask

    initial begin
        int ends;
        int end1;
        int end2;
        logic [31:0] q1, r1, q2, r2;

        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        div_begin = 1'b0;
        div_sign  = 1'b0;
        div_op1   = '0;
        div_op2   = '0;

        repeat (2) @(negedge clk);
        check("reset_q", div_result, 32'h0);
        check("reset_r", div_remainder, 32'h0);
        check("reset_end", {31'b0, div_end}, 32'h0);
        rst = 1'b0;

        do_div("u100_7",  32'd100,      32'd7,        1'b0, 32'h0000000E, 32'h00000002);
        do_div("s_m7_2",  32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF);
        do_div("s_7_m2",  32'h00000007, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'h00000001);
        do_div("s_ovf",   32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h00000000);
        do_div("s_m100_m7", 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'h0000000E, 32'hFFFFFFFE);
        do_div("u_big",   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000);
        do_div("u_dz",    32'h12345678, 32'h00000000, 1'b0, 32'hFFFFFFFF, 32'h12345678);
        do_div("s_dz",    32'h12345678, 32'h00000000, 1'b1, 32'hFFFFFFFF, 32'h12345678);
        do_div("s_dz_neg", 32'h87654321, 32'h00000000, 1'b1, 32'hFFFFFFFF, 32'h87654321);

        // Abort at cycle 10: no div_end, previous results untouched.
        @(negedge clk);
        div_op1   = 32'd1000;
        div_op2   = 32'd3;
        div_sign  = 1'b0;
        div_begin = 1'b1;
        @(posedge clk);
        ends = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (div_end) ends++;
            if (k == 10) div_begin = 1'b0;
        end
        check("abort_no_end", ends, 0);
        check("abort_q_hold", div_result, 32'hFFFFFFFF);
        check("abort_r_hold", div_remainder, 32'h87654321);
        do_div("after_abort", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1);

        // Back-to-back with div_begin held continuously.
        @(negedge clk);
        div_op1   = 32'd100;
        div_op2   = 32'd7;
        div_sign  = 1'b0;
        div_begin = 1'b1;
        @(posedge clk);
        ends = 0;
        end1 = 0;
        end2 = 0;
        q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        for (int k = 1; k <= 75; k++) begin
            @(negedge clk);
            if (div_end) begin
                ends++;
                if (end1 == 0) begin
                    end1 = k; q1 = div_result; r1 = div_remainder;
                end else if (end2 == 0) begin
                    end2 = k; q2 = div_result; r2 = div_remainder;
                end
            end
            if (k == 33) begin
                div_op1 = 32'hFFFFFFFF;
                div_op2 = 32'd16;
            end
            if (k == 67) div_begin = 1'b0;
        end
        check("b2b_end1", end1, 33);
        check("b2b_q1", q1, 32'h0000000E);
        check("b2b_r1", r1, 32'h00000002);
        check("b2b_end2", end2, 67);
        check("b2b_q2", q2, 32'h0FFFFFFF);
        check("b2b_r2", r2, 32'h0000000F);
        check("b2b_count", ends, 2);

        // Asynchronous reset in cycle 20 of a division.
        @(negedge clk);
        div_op1   = 32'd500;
        div_op2   = 32'd9;
        div_begin = 1'b1;
        @(posedge clk);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_q", div_result, 32'h0);
        check("midrst_r", div_remainder, 32'h0);
        check("midrst_end", {31'b0, div_end}, 32'h0);
        div_begin = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_div("after_rst", 32'd500, 32'd9, 1'b0, 32'd55, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle radix-2 restoring integer divider serving the EXE stage of the five-stage pipeline. It is the responder side of the EXE divide handshake. EXE holds `div_begin` high (`divide & EXE_valid`) together with the operands and sign mode, and stalls `EXE_over` until `div_end`. The divider returns a 32-bit quotient and remainder for DIV/DIVU, which EXE forwards to LO/HI.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported in this pipeline.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `div_begin`  in  1  level request; high while EXE holds a valid divide.
- `div_sign`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start.
- `div_op1`  in  WIDTH  dividend (rs); sampled at start.
- `div_op2`  in  WIDTH  divisor (rt); sampled at start.
- `div_result`  out  WIDTH  quotient, registered.
- `div_remainder`  out  WIDTH  remainder, registered.
- `div_end`  out  1  completion strobe, high for exactly one cycle.

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- **IDLE**
  - `div_begin`=1 at an edge: capture |op1|, |op2| into working registers (absolute value only when `div_sign`=1).
  - At the same edge: capture the quotient sign (op1[31]^op2[31]) and remainder sign (op1[31]), both gated by `div_sign`.
  - At the same edge: capture the divisor-zero flag, clear the 6-bit counter, and go to BUSY.
- **BUSY**, one quotient bit per edge, MSB first, restoring algorithm.
  - Shift `{rem, dividend}` left by 1, then trial-subtract the divisor from the upper 33 bits.
  - Non-negative trial: keep the difference and shift in quotient bit 1. Otherwise restore and shift in 0.
  - After 32 iterations (counter = 31 at the edge), load `div_result` and `div_remainder` with the sign-corrected values and go to DONE.
- **BUSY abort:** if `div_begin`=0 at any BUSY edge (EXE flushed by an exception or eret), go to IDLE. Outputs are untouched and `div_end` is not asserted.
- **DONE:** `div_end`=1 for this cycle; the next edge unconditionally returns to IDLE.
- **Sign correction:** negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set. The remainder takes the sign of the dividend and |rem| < |divisor|.
- **Divisor zero:** `div_result`=0xFFFFFFFF and `div_remainder`=op1 as captured (original, not absolute), for both sign modes. No exception is raised.
- **Signed overflow** (0x80000000 / 0xFFFFFFFF): `div_result`=0x80000000, `div_remainder`=0. This falls out naturally from 32-bit unsigned magnitudes.
- All arithmetic uses a 33-bit trial subtractor, so there is no magnitude overflow for |0x80000000|.
- `div_result` and `div_remainder` hold their last values until the next completed division.

## Timing
- Start edge E0 (IDLE, `div_begin`=1). Iterations run on E1..E32; the results are registered at E32.
- `div_end`=1 in the cycle between E32 and E33, i.e. the 33rd cycle after E0.
- EXE must capture the results in the `div_end` cycle; the outputs stay stable afterwards anyway.
- DONE→IDLE at E33. If `div_begin` is still high at E34 (back-to-back divide), a new division starts with the operands present at E34. Minimum issue interval is 34 cycles.
- Operand changes during BUSY are ignored, since the captured copies are used.
- **Reset:** asynchronous `rst`=1 at any time forces state IDLE, counter 0, `div_result`=0, `div_remainder`=0, `div_end`=0. It takes effect immediately, mid-division included.
- After `rst` deasserts, the first start is sampled on the first edge with `div_begin`=1.
- `div_end` is decoded from state DONE only, so it never glitches high in IDLE or BUSY.

## Test plan
- Unsigned 100/7, `div_begin` held from E0 → `div_end` only in cycle 33; q=0x0000000E, r=0x00000002.
- Signed cases:
  - −7/2 (0xFFFFFFF9/0x00000002) → q=0xFFFFFFFD, r=0xFFFFFFFF.
  - 7/−2 → q=0xFFFFFFFD, r=0x00000001.
  - 0x80000000/0xFFFFFFFF → q=0x80000000, r=0.
- Divide by zero, signed and unsigned: 0x12345678/0 → q=0xFFFFFFFF, r=0x12345678; `div_end` still at cycle 33.
- Abort: drop `div_begin` at cycle 10 → no `div_end` for 40 cycles, previous results unchanged. Re-raise `div_begin` → full 33-cycle division.
- Back-to-back: 100/7 then 0xFFFFFFFF/16 unsigned with `div_begin` held continuously → first `div_end` at cycle 33 (14, 2); second at cycle 67 (0x0FFFFFFF, 0xF).
- Assert `rst` at cycle 20 of a division → outputs immediately 0 and state IDLE. After release, `div_begin`=1 starts a fresh division with correct results.
